// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, runtime baud divider,
// selectable parity (none/even/odd) and one or two stop bits.
// Frames are sent LSB-first: start(0), DATA_BITS data, optional parity, stop(1).
//
// Handshake: a word on tx_data is accepted on any clk edge where
// tx_valid && tx_ready. tx_ready depends only on the registered fifo_count
// (never on tx_valid or on a same-cycle pop); tx_valid while !tx_ready is
// ignored with no side effect, and the producer keeps its word until accepted.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 txd,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_count,
    output logic [2:0]           state_dbg
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;

    // Frame context, all captured when the word is popped.
    logic [DATA_BITS-1:0] shreg;
    logic [DIV_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     bit_term;   // latched divider minus one
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2_lat;
    logic                 stop_idx;

    logic                 push;
    logic                 pop;
    logic                 bit_last;
    logic                 frame_end;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    assign tx_ready  = fifo_count < FULL_CNT;
    assign push      = tx_valid && tx_ready;
    assign bit_last  = bit_cnt == bit_term;
    assign frame_end = (state == S_STOP) && bit_last && (!stop2_lat || stop_idx);
    // Pop only from IDLE or on the last clock of STOP, so frames chain without a gap.
    assign pop       = (fifo_count != '0) && ((state == S_IDLE) || frame_end);
    assign head      = mem[rd_ptr];
    assign head_par  = (parity_mode == 2'b10) ? ~(^head) : ^head;
    assign state_dbg = state;

    // FIFO storage: written on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transmit FSM with registered txd/busy; each bit is held for bit_term+1 clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            txd       <= 1'b1;
            busy      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            bit_term  <= '0;
            bit_idx   <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            stop2_lat <= 1'b0;
            stop_idx  <= 1'b0;
        end else if (pop) begin
            // New frame: latch word and configuration, drive the start bit now.
            state     <= S_START;
            txd       <= 1'b0;
            busy      <= 1'b1;
            shreg     <= head;
            bit_cnt   <= '0;
            bit_term  <= (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
            bit_idx   <= '0;
            par_en    <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit   <= head_par;
            stop2_lat <= stop2;
            stop_idx  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                end
                S_START: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        state   <= S_DATA;
                        txd     <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == LAST_IDX) begin
                            if (par_en) begin
                                state <= S_PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= S_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        state   <= S_STOP;
                        txd     <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (stop2_lat && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            // FIFO empty at end of frame (a pop is handled above).
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            txd   <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a built-in transmit FIFO, runtime baud divider, selectable parity (none/even/odd) and 1 or 2 stop bits. It replaces the fixed 8-bit, one-bit-per-clock, even-parity transmitter. It sits between the host-side byte producer (valid/ready handshake) and the serial TXD pin. Frame format is LSB-first: start(0), DATA_BITS data, optional parity, stop(1).

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
DIV_W, 16, width of the baud_div input.
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
tx_data  input  DATA_BITS  word to enqueue.
tx_valid  input  1  producer has a word on tx_data.
tx_ready  output  1  FIFO can accept a word this cycle.
baud_div  input  DIV_W  clocks per serial bit; 0 is treated as 1.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
stop2  input  1  1 = two stop bits, 0 = one stop bit.
txd  output  1  serial line, registered, idles high.
busy  output  1  a frame is in progress (state != IDLE).
fifo_count  output  FIFO_AW+1  number of words currently queued.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): txd=1, busy=0, tx_ready=1, fifo_count=0, state=IDLE, FIFO pointers=0. Any partial frame is abandoned; the line returns high immediately.
- Enqueue: a word is written on any clk edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count < 2**FIFO_AW), purely from the registered count.
  - A same-cycle pop does not raise tx_ready.
  - tx_valid while !tx_ready is ignored, with no side effect.
- Dequeue:
  - In IDLE with fifo_count != 0, the head word is popped on that edge and latched into the shift register.
  - baud_div (0->1), parity_mode and stop2 are latched on the same edge.
  - Config changes mid-frame have no effect until the next frame.
- Push and pop on the same edge: fifo_count unchanged, both pointers advance.
- There is no bypass. A word pushed into an empty FIFO is popped on the following edge at the earliest.
- Latency: push at edge N into an empty FIFO while IDLE -> pop at edge N+1 -> txd=0 (START) from edge N+1. busy rises at the same edge.
- State machine: IDLE -> START -> DATA -> PARITY (skipped if mode none/11) -> STOP -> IDLE or START.
  - Each of START, each data bit, PARITY and each stop bit holds txd for exactly B clocks, where B is the latched divider.
  - A per-bit counter runs 0..B-1; a bit index runs 0..DATA_BITS-1 in DATA.
  - The STOP phase lasts B clocks (stop2=0) or 2B clocks (stop2=1).
- Back-to-back frames: at the end of STOP, if fifo_count != 0, the next word is popped and the FSM goes directly to START. No extra idle clock is inserted, and busy stays 1. Otherwise the FSM goes to IDLE with txd=1.
- Parity is computed over the latched data word:
  - even: parity bit = XOR(data), so the total count of ones is even.
  - odd: parity bit = ~XOR(data).
- Frame length in clocks: B*(1 + DATA_BITS + P + S), where P is 0 or 1 and S is 1 or 2.
- Counter widths:
  - Bit counter: DIV_W bits; it never wraps, because the terminal count is B-1.
  - fifo_count: FIFO_AW+1 bits, range 0..2**FIFO_AW.
  - Pointers: FIFO_AW bits, wrapping modulo depth.

Test Plan:
- Reset, then no stimulus for 20 clocks -> txd=1, busy=0, tx_ready=1, fifo_count=0 throughout.
- Single frame: baud_div=4, parity_mode=01, stop2=0, push 0xA5 -> 44 clocks on txd of 0, 1,0,1,0,0,1,0,1, 0, 1 (each held 4 clocks). Start begins 1 edge after the push. busy falls after 44 clocks.
- Parity and stop variants on 0xA5 with baud_div=2:
  - mode 10 -> parity bit 1.
  - mode 00 with stop2=1 -> no parity bit, 2 stop bits, 22 clocks total.
  - mode 11 behaves like mode 00.
- FIFO full and back-to-back: baud_div=1, push 0x01,0x02,0x03,0x04,0x05 on consecutive edges.
  - FIFO_AW=2 must accept all five (the first word is popped before the FIFO fills).
  - tx_ready deasserts when fifo_count reaches 4.
  - A push attempted while !tx_ready is dropped.
  - Frames are emitted contiguously with no idle high gap between stop and start, and busy stays 1.
- Config latching: start a frame with baud_div=3, change to 8 mid-frame -> current frame keeps 3 clocks per bit, next frame uses 8. baud_div=0 yields 1 clock per bit.
- Reset mid-DATA with 2 words queued -> txd=1 immediately, fifo_count=0, busy=0. A push after release produces a clean frame.
